// File: rtl/msg_commit_fifo.sv
// Packet-commit buffer feeding the FX2 slave-FIFO controller: words become visible only once a whole message lands.
// Optional feature macro MSG_SYNC_HEADER_EN prefixes every message with the 16'h55AA sync word.
module msg_commit_fifo #(
    parameter int ADDR_W  = 10,
    parameter int MAX_LEN = 254
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [15:0]     DIN,
    input  logic            DIN_VALID,
    input  logic            DIN_LAST,
    input  logic            RD_REQ,
    output logic [15:0]     fifo_q,
    output logic            GOT_FULL_MSG,
    output logic [ADDR_W:0] committed_words,
    output logic            OVERFLOW,
    output logic [7:0]      drop_cnt,
    output logic [1:0]      dbg_state_o
);
    // Write side: DIN is taken on any edge where DIN_VALID is high (no back-pressure);
    // read side: RD_REQ consumes the show-ahead word fifo_q only when committed_words != 0.
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [15:0]     SYNC_WORD = 16'h55AA;
    localparam logic [8:0]      LEN_LIMIT = 9'(MAX_LEN);
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_DROP = 2'd2
    } state_t;

`ifdef MSG_SYNC_HEADER_EN
    localparam state_t MSG_START = S_IDLE;
`else
    localparam state_t MSG_START = S_BODY;
`endif

    state_t          state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]      len_q, len_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic [15:0]     mem_q [DEPTH];

    logic [ADDR_W:0] used_w;
    logic [ADDR_W:0] committed_w;
    logic            full_w;
    logic            rd_en_w;
    logic            we_w;
    logic [15:0]     wdata_w;
    logic            drop_w;

    // Pointers carry one extra bit so used == DEPTH is distinguishable from empty.
    assign used_w      = wr_ptr_q - rd_ptr_q;
    assign full_w      = used_w[ADDR_W];
    assign committed_w = commit_ptr_q - rd_ptr_q;
    assign rd_en_w     = RD_REQ && (committed_w != '0);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        we_w         = 1'b0;
        wdata_w      = DIN;
        drop_w       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A word arriving while the header slot is being written is illegal.
                if (DIN_VALID) begin
                    drop_w  = 1'b1;
                    state_d = DIN_LAST ? S_IDLE : S_DROP;
                end else if (!full_w) begin
                    we_w     = 1'b1;
                    wdata_w  = SYNC_WORD;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    len_d    = 9'd0;
                    state_d  = S_BODY;
                end
            end
            S_BODY: begin
                if (DIN_VALID) begin
                    if (full_w || (len_q == LEN_LIMIT)) begin
                        drop_w   = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        len_d    = 9'd0;
                        state_d  = DIN_LAST ? MSG_START : S_DROP;
                    end else begin
                        we_w     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        len_d    = len_q + 9'd1;
                        if (DIN_LAST) begin
                            commit_ptr_d = wr_ptr_q + PTR_ONE;
                            len_d        = 9'd0;
                            state_d      = MSG_START;
                        end
                    end
                end
            end
            S_DROP: begin
                if (DIN_VALID && DIN_LAST) begin
                    len_d   = 9'd0;
                    state_d = MSG_START;
                end
            end
            default: begin
                state_d = MSG_START;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d   = rd_en_w ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ovf_d      = drop_w;
        drop_cnt_d = drop_cnt_q;
        if (drop_w && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= MSG_START;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            len_q        <= 9'd0;
            ovf_q        <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (we_w) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_w;
        end
    end

    assign fifo_q          = (committed_w != '0) ? mem_q[rd_ptr_q[ADDR_W-1:0]] : 16'h0000;
    assign GOT_FULL_MSG    = (committed_w != '0);
    assign committed_words = committed_w;
    assign OVERFLOW        = ovf_q;
    assign drop_cnt        = drop_cnt_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_msg_commit_fifo.sv
// Self-checking bench for msg_commit_fifo against a queue-based message model; honours MSG_SYNC_HEADER_EN.
module tb_msg_commit_fifo;
  localparam int ADDR_W  = 4;
  localparam int MAX_LEN = 10;
  localparam int DEPTH   = 1 << ADDR_W;
`ifdef MSG_SYNC_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     din;
  logic            din_valid;
  logic            din_last;
  logic            rd_req;
  logic [15:0]     fifo_q;
  logic            got_full;
  logic [ADDR_W:0] committed;
  logic            ovf;
  logic [7:0]      drop_cnt;
  logic [1:0]      dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: committed words, the open (uncommitted) message, drop bookkeeping.
  logic [15:0] exp_q[$];
  logic [15:0] pend_q[$];
  bit          opened;
  bit          dropping;
  bit          exp_ovf;
  int          exp_drops;

  msg_commit_fifo #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .CLK             (clk),
    .RST             (rst_n),
    .DIN             (din),
    .DIN_VALID       (din_valid),
    .DIN_LAST        (din_last),
    .RD_REQ          (rd_req),
    .fifo_q          (fifo_q),
    .GOT_FULL_MSG    (got_full),
    .committed_words (committed),
    .OVERFLOW        (ovf),
    .drop_cnt        (drop_cnt),
    .dbg_state_o     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    opened    = 0;
    dropping  = 0;
    exp_ovf   = 0;
    exp_drops = 0;
  endtask

  task automatic note_drop();
    exp_ovf = 1;
    if (exp_drops < 255) exp_drops++;
  endtask

  // One clock edge of the message-level rules, all decisions on pre-edge occupancy.
  task automatic model_edge(input logic [15:0] d, input bit v, input bit l, input bit r);
    int used;
    int free;
    int payload;
    bit pop;
    used    = exp_q.size() + pend_q.size();
    free    = DEPTH - used;
    payload = pend_q.size() - HDR;
    pop     = r && (exp_q.size() != 0);
    exp_ovf = 0;
    if (dropping) begin
      if (v && l) dropping = 0;
    end else if (HDR == 1 && !opened) begin
      if (v) begin
        note_drop();
        dropping = !l;
      end else if (free > 0) begin
        pend_q.push_back(16'h55AA);
        opened = 1;
      end
    end else if (v) begin
      if (free == 0 || payload == MAX_LEN) begin
        pend_q.delete();
        note_drop();
        dropping = !l;
        opened   = 0;
      end else begin
        pend_q.push_back(d);
        if (l) begin
          foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
          pend_q.delete();
          opened = 0;
        end
      end
    end
    if (pop) void'(exp_q.pop_front());
  endtask

  task automatic check_outputs();
    check("committed_words", 32'(committed), 32'(exp_q.size()));
    check("got_full_msg", 32'(got_full), 32'(exp_q.size() != 0));
    check("fifo_q", 32'(fifo_q), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    check("overflow", 32'(ovf), 32'(exp_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [15:0] d, input bit v, input bit l, input bit r);
    din       = d;
    din_valid = v;
    din_last  = l;
    rd_req    = r;
    @(posedge clk);
    model_edge(d, v, l, r);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int rd_pct);
    for (int i = 0; i < n; i++) cycle(16'h0, 0, 0, $urandom_range(99) < rd_pct);
  endtask

  task automatic send_msg(input int n, input int rd_pct, input int bubble_pct);
    int  k;
    logic r;
    k = 0;
    while (k < n) begin
      r = ($urandom_range(99) < rd_pct);
      if ($urandom_range(99) < bubble_pct) begin
        cycle(16'h0, 0, 0, r);
      end else begin
        cycle(16'($urandom), 1, (k == n - 1), r);
        k++;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 16'h0;
    din_valid = 1'b0;
    din_last  = 1'b0;
    rd_req    = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_committed", 32'(committed), 32'h0);
    check("rst_got_full", 32'(got_full), 32'h0);
    check("rst_fifo_q", 32'(fifo_q), 32'h0);
    check("rst_overflow", 32'(ovf), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;
    cycle(16'h0, 0, 0, 1);

    // Fixed three-word message, then drained word by word.
    idle(1, 0);
    cycle(16'h0001, 1, 0, 0);
    cycle(16'h0002, 1, 0, 0);
    check("msg1_not_yet", 32'(got_full), 32'h0);
    cycle(16'h0003, 1, 1, 0);
    check("msg1_count", 32'(committed), 32'(HDR + 3));
    for (int i = 0; i < HDR + 3; i++) cycle(16'h0, 0, 0, 1);
    check("msg1_drained", 32'(got_full), 32'h0);

    // Buffer-space overflow, then recovery.
    idle(1, 0);
    send_msg(9, 0, 0);
    idle(1, 0);
    send_msg(8, 0, 0);
    check("space_drop_cnt", 32'(drop_cnt), 32'h1);
    check("space_keep", 32'(committed), 32'(HDR + 9));
    idle(DEPTH + 2, 100);
    send_msg(2, 0, 0);
    check("post_ovf_commit", 32'(committed), 32'(HDR + 2));
    idle(6, 100);

    // Length limit: one over is dropped, exactly MAX_LEN commits.
    idle(1, 0);
    send_msg(MAX_LEN + 1, 0, 0);
    check("len_drop_cnt", 32'(drop_cnt), 32'h2);
    idle(1, 0);
    send_msg(MAX_LEN, 0, 0);
    check("len_max_commit", 32'(committed), 32'(HDR + MAX_LEN));
    idle(DEPTH, 100);

    // Next message starting right after DIN_LAST.
    idle(1, 0);
    send_msg(2, 0, 0);
    send_msg(3, 0, 0);
    check("b2b_committed", 32'(committed), (HDR == 1) ? 32'(HDR + 2) : 32'd5);
    idle(8, 100);

    // Continuous reads while a second message streams in.
    idle(1, 0);
    send_msg(5, 0, 0);
    idle(1, 100);
    send_msg(6, 100, 0);
    idle(10, 100);

    // Reset in the middle of a message.
    idle(1, 0);
    for (int i = 0; i < 3; i++) cycle(16'($urandom), 1, 0, 0);
    din_valid = 1'b0;
    din_last  = 1'b0;
    rd_req    = 1'b0;
    rst_n     = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with bubbles, gaps and concurrent reads.
    for (int m = 0; m < 200; m++) begin
      idle($urandom_range(0, 2), 50);
      send_msg($urandom_range(1, MAX_LEN + 3), 40, 15);
    end
    idle(DEPTH + 4, 100);

    // Drop counter saturation.
    for (int m = 0; m < 260; m++) begin
      idle(1, 100);
      send_msg(MAX_LEN + 1, 0, 0);
    end
    check("drop_saturate", 32'(drop_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/msg_commit_fifo.md
# msg_commit_fifo

Packet-commit buffer sitting directly upstream of the FX2 slave-FIFO read/write controller. Accepts 16-bit words from the capture side, optionally prefixes each message with sync word 16'h55AA, and exposes words to the controller only after the whole message has been received. It drives the controller's `GOT_FULL_MSG` and `fifo_q` and consumes its `RD_REQ`. Overflowing or over-length messages are rolled back and dropped whole.

## Interface
- `ADDR_W`, default 10: buffer depth is 2^ADDR_W words.
- `MAX_LEN`, default 254: maximum payload words per message, excluding the header.

Ports:
- `CLK`  in  1  single clock for the whole block.
- `RST`  in  1  reset, asynchronous, active-low.
- `DIN`  in  16  input data word.
- `DIN_VALID`  in  1  `DIN` is valid this cycle.
- `DIN_LAST`  in  1  qualifies the last word of a message; meaningful only with `DIN_VALID`.
- `RD_REQ`  in  1  consume the current head word.
- `fifo_q`  out  16  show-ahead head word; 16'h0000 when no committed data.
- `GOT_FULL_MSG`  out  1  committed words available (`committed_words != 0`).
- `committed_words`  out  ADDR_W+1  committed but unread word count.
- `OVERFLOW`  out  1  one-cycle pulse when a message is dropped.
- `drop_cnt`  out  8  dropped-message count, saturates at 255.

## Operation
- Three pointers, each ADDR_W+1 bits, wrapping naturally:
  - `wr_ptr`: speculative write pointer.
  - `commit_ptr`: end of committed data.
  - `rd_ptr`: read head.
- Derived quantities:
  - `committed_words` = `commit_ptr - rd_ptr`.
  - free = 2^ADDR_W − (`wr_ptr - rd_ptr`).
- State machine with states IDLE, BODY, DROP. A 9-bit length counter tracks payload words in the current message.
- **IDLE**
  - If free ≥ 1: write 16'h55AA at `wr_ptr`, advance `wr_ptr`, clear the length counter, go to BODY.
  - If `DIN_VALID` is seen in IDLE, the word is illegal: drop the message. Go to DROP, or stay in IDLE if `DIN_LAST` is also set.
- **BODY**, on `DIN_VALID`:
  - If free = 0 or the length counter = `MAX_LEN`: roll back (`wr_ptr` ← `commit_ptr`) and pulse `OVERFLOW`. Increment `drop_cnt` unless it is already at 255. Go to IDLE if `DIN_LAST`, else go to DROP.
  - Otherwise: write `DIN`, advance `wr_ptr`, and increment the length counter.
  - If `DIN_LAST` is set and the word was written: set `commit_ptr` to the new `wr_ptr`, then go to IDLE.
- **DROP**: discard every word; on `DIN_VALID && DIN_LAST`, go to IDLE.
- **Read side**
  - `RD_REQ` with `committed_words` ≠ 0: `rd_ptr` increments.
  - `RD_REQ` with `committed_words` = 0: ignored.
  - `fifo_q` = mem[`rd_ptr`] (combinational read) when `committed_words` ≠ 0, else 16'h0000.
- Read and write in the same cycle are both honoured. Free-space and commit decisions use pre-edge pointers.
- Reset mid-message: everything clears and the partial message is lost. The memory array itself is not reset.

## Timing
- Reset values:
  - State IDLE; all pointers 0.
  - `GOT_FULL_MSG`=0, `committed_words`=0, `fifo_q`=16'h0000.
  - `OVERFLOW`=0, `drop_cnt`=0.
- Commit latency: on the edge that samples `DIN_VALID && DIN_LAST`, `GOT_FULL_MSG` and `committed_words` update immediately after that edge.
- `fifo_q` shows the next word immediately after the edge that samples `RD_REQ`. The controller drives `RD_REQ` with `SLWR`, so each word is held stable for a full cycle.
- `GOT_FULL_MSG` falls immediately after the edge consuming the last committed word. This lets the controller end a packet when its check of `GOT_FULL_MSG` fails.
- Header write costs one IDLE cycle. Upstream must leave at least one idle cycle between `DIN_LAST` and the next message's first word.
- `OVERFLOW` is high for exactly the one cycle following the dropping edge.

## Configuration
- `MSG_SYNC_HEADER_EN` defined:
  - IDLE writes the 16'h55AA header as described.
  - The one-cycle inter-message gap is required.
- Not defined:
  - No header is written and IDLE is merged into BODY.
  - `DIN_VALID` in any non-DROP state is accepted, so back-to-back messages need no gap.
  - Committed messages contain only payload.

## Test plan
- Reset, with `DIN_VALID` low and `RD_REQ` pulsed → all outputs at reset values; `rd_ptr` stays 0.
- Message 16'h0001, 16'h0002, 16'h0003 (`DIN_LAST` on the third) → `GOT_FULL_MSG` stays 0 until after the `DIN_LAST` edge, then `committed_words`=4. Four `RD_REQ`s return 55AA, 0001, 0002, 0003, and `GOT_FULL_MSG`=0 after the fourth.
- `ADDR_W`=4, 20-word message → `OVERFLOW` pulse, `drop_cnt`=1, `committed_words`=0. A following 2-word message commits with `committed_words`=3.
- `MAX_LEN`=4, 5-word message → dropped with `drop_cnt`=1. A following 4-word message commits with `committed_words`=5.
- `DIN_VALID` asserted in the cycle right after `DIN_LAST` (header enabled), 3-word message → the new message is dropped and the previous committed message is intact.
- Continuous `RD_REQ` while a second message is streaming → first message drains in order. The second message does not appear (`fifo_q`=0, `GOT_FULL_MSG`=0) until its `DIN_LAST`.
